// File: rtl/frame_decoder.sv
// Receive-side frame decoder: finds frame boundaries from marker pulses, strips the
// fixed left padding, buffers the payload and replays it on a valid/ready port.
module frame_decoder #(
    parameter int SIZE      = 20,
    parameter int PAD_LEFT  = 80,
    parameter int LEN_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           din,
    input  logic                 marker,
    output logic [7:0]           dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic                 frame_done,
    output logic                 overflow
);
    // state   | meaning
    // IDLE    | waiting for a start marker
    // SKIP    | counting through the left padding
    // CAPTURE | writing payload bytes into the buffer until the end marker
    // DRAIN   | replaying the buffered payload on the output port

    localparam int CNT_W = $clog2(PAD_LEFT + 1);
    localparam logic [CNT_W-1:0]     PAD_END = CNT_W'(PAD_LEFT - 1);
    localparam logic [LEN_WIDTH-1:0] SIZE_L  = LEN_WIDTH'(SIZE);

    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} state_t;

    state_t               state;
    logic [CNT_W-1:0]     pad_cnt;
    logic [LEN_WIDTH-1:0] wr_ptr;
    logic [LEN_WIDTH-1:0] rd_ptr;
    logic [LEN_WIDTH-1:0] rd_next;
    logic [7:0]           buffer [SIZE];
    logic                 wr_en;

    assign wr_en   = (state == CAPTURE) && !marker && (wr_ptr != SIZE_L);
    assign rd_next = rd_ptr + 1'b1;

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pad_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (marker) begin
                        state    <= SKIP;
                        pad_cnt  <= CNT_W'(1);
                        overflow <= 1'b0;
                    end
                end
                SKIP: begin
                    if (marker) begin
                        pad_cnt  <= CNT_W'(1);
                        overflow <= 1'b0;
                    end else if (pad_cnt == PAD_END) begin
                        state  <= CAPTURE;
                        wr_ptr <= '0;
                    end else begin
                        pad_cnt <= pad_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (marker) begin
                        frame_len <= wr_ptr;
                        if (wr_ptr == '0) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state      <= DRAIN;
                            rd_ptr     <= '0;
                            dout       <= buffer[0];
                            dout_valid <= 1'b1;
                            dout_last  <= (wr_ptr == LEN_WIDTH'(1));
                        end
                    end else if (wr_ptr == SIZE_L) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (dout_valid && dout_ready) begin
                        if (dout_last) begin
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rd_ptr    <= rd_next;
                            dout      <= buffer[rd_next];
                            dout_last <= (rd_next == frame_len - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_decoder.sv
// Directed bench for frame_decoder: nominal, stalled, overflow, empty, restart and reset frames.
module tb_frame_decoder;
    localparam int SIZE      = 20;
    localparam int PAD_LEFT  = 80;
    localparam int LEN_WIDTH = 5;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [7:0]           din;
    logic                 marker;
    logic [7:0]           dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic [LEN_WIDTH-1:0] frame_len;
    logic                 frame_done;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] payload [0:31];

    frame_decoder #(.SIZE(SIZE), .PAD_LEFT(PAD_LEFT), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .marker     (marker),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Marker cycle plus PAD_LEFT-1 padding cycles; the next step captures byte 0.
    task automatic start_frame();
        marker = 1'b1;
        din    = 8'h5A;
        step();
        marker = 1'b0;
        din    = 8'h99;
        repeat (PAD_LEFT - 1) step();
    endtask

    // n payload bytes then the end marker; returns observing cycle E+1.
    task automatic send_payload(input int n);
        for (int i = 0; i < n; i++) begin
            din = payload[i];
            step();
        end
        marker = 1'b1;
        din    = 8'hEE;
        step();
        marker = 1'b0;
        din    = 8'h00;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic drain(input string tag, input int n, input int mode);
        int idx = 0;
        int cyc = 0;
        bit held = 1'b0;
        bit done = 1'b0;
        bit rdy;
        logic [7:0] hd;
        logic hl;
        while (!done && cyc < 300) begin
            chk({tag, "_valid"}, dout_valid, 1);
            if (held) begin
                chk({tag, "_hold_data"}, dout, hd);
                chk({tag, "_hold_last"}, dout_last, hl);
            end
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            dout_ready = rdy;
            if (rdy) begin
                chk({tag, "_data"}, dout, payload[idx]);
                chk({tag, "_last"}, dout_last, (idx == n - 1));
                idx++;
                held = 1'b0;
                if (idx == n) done = 1'b1;
            end else begin
                held = 1'b1;
                hd   = dout;
                hl   = dout_last;
            end
            step();
            cyc++;
        end
        dout_ready = 1'b1;
        chk({tag, "_count"}, idx, n);
        if (mode == 0) chk({tag, "_cycles"}, cyc, n);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_valid_off"}, dout_valid, 0);
        chk({tag, "_dout_zero"}, dout, 0);
        step();
        chk({tag, "_done_width"}, frame_done, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        din        = 8'h00;
        marker     = 1'b0;
        dout_ready = 1'b1;
        #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovf", overflow, 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Nominal three-byte frame
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        start_frame();
        send_payload(3);
        chk("f1_len", frame_len, 3);
        chk("f1_ovf", overflow, 0);
        drain("f1", 3, 0);

        // Same frame with a stalling sink
        start_frame();
        send_payload(3);
        chk("f2_len", frame_len, 3);
        drain("f2", 3, 1);

        // 25 bytes into a 20-byte buffer
        for (int i = 0; i < 25; i++) payload[i] = 8'(i + 1);
        start_frame();
        chk("ovf_clear_pre", overflow, 0);
        send_payload(25);
        chk("ovf_len", frame_len, 20);
        chk("ovf_set", overflow, 1);
        drain("ovf", 20, 0);
        repeat (3) step();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_len_hold", frame_len, 20);

        // Empty frame: end marker on the first capture cycle
        start_frame();
        chk("ovf_cleared", overflow, 0);
        marker = 1'b1;
        step();
        marker = 1'b0;
        chk("empty_done", frame_done, 1);
        chk("empty_len", frame_len, 0);
        chk("empty_valid", dout_valid, 0);
        step();
        chk("empty_done_width", frame_done, 0);
        chk("empty_valid2", dout_valid, 0);

        // Restart marker at T+40 moves capture to T+120
        marker = 1'b1;
        din    = 8'h5A;
        step();
        marker = 1'b0;
        din    = 8'h77;
        repeat (39) step();
        start_frame();
        payload[0] = 8'hA1; payload[1] = 8'hA2;
        send_payload(2);
        chk("restart_len", frame_len, 2);
        drain("restart", 2, 0);

        // Reset in the middle of a capture
        payload[0] = 8'hC1; payload[1] = 8'hC2; payload[2] = 8'hC3;
        start_frame();
        din = 8'hC1;
        step();
        din = 8'hC2;
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_len", frame_len, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_done", frame_done, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_done", frame_done, 0);
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        start_frame();
        send_payload(3);
        chk("post_rst_len", frame_len, 3);
        drain("post_rst", 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
